// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-port image-ROM arbiter.
// Optional statistics counters are enabled by defining ROM_ARB_STATS_EN.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        S_VIS   = 2'd0,
        S_BLANK = 2'd1,
        S_BURST = 2'd2
    } state_t;

    localparam logic ID_D = 1'b0;
    localparam logic ID_A = 1'b1;

    localparam int ROM_LAT_MIN = 1;
    localparam int ROM_LAT_MAX = 4;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    // Out-of-range latencies are pulled back into the supported window.
    function automatic int clamp_lat(input int lat);
        if (lat < ROM_LAT_MIN) return ROM_LAT_MIN;
        if (lat > ROM_LAT_MAX) return ROM_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/rom_arb_tag_pipe.sv
// Delay line carrying {valid, id} alongside each ROM read so the returned
// word can be steered to its requester; cleared asynchronously on reset.
module rom_arb_tag_pipe
    import rom_arb_pkg::*;
#(
    parameter int ROM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t i_tag,
    output tag_t o_tag
);

    localparam int DEPTH = clamp_lat(ROM_LAT);

    tag_t w_chain [DEPTH+1];

    assign w_chain[0] = i_tag;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            tag_t r_tag;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tag <= '0;
                end else begin
                    r_tag <= w_chain[gi];
                end
            end
            assign w_chain[gi+1] = r_tag;
        end
    endgenerate

    assign o_tag = w_chain[DEPTH];

endmodule

// File: rtl/rom_arbiter.sv
// Two-requester arbiter in front of the image ROM: display has priority during
// visible video, round-robin in blanking, locked aux bursts. Macro: ROM_ARB_STATS_EN.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 12,
    parameter int ROM_LAT   = 1,
    parameter int BURST_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vis_active,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_burst,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_d_grants,
    output logic [15:0]       stat_a_grants,
    output logic [15:0]       stat_d_blocked
`endif
);

    localparam logic [7:0] BURST_MAX_C   = 8'(BURST_MAX);
    localparam bit         BURST_ALLOWED = (BURST_MAX > 1);

    state_t            r_state;
    logic              r_rr_last;
    logic [7:0]        r_burst_cnt;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_d_rvalid;
    logic              r_a_rvalid;

    state_t            w_pol;
    logic              w_d_gnt;
    logic              w_a_gnt;
    logic              w_conflict;
    logic [7:0]        w_cnt_inc;
    tag_t              w_tag_in;
    tag_t              w_tag_out;

    // vis_active overrides the registered state within the same cycle.
    always_comb begin
        w_pol = S_BLANK;
        if (vis_active)               w_pol = S_VIS;
        else if (r_state == S_BURST)  w_pol = S_BURST;
    end

    assign w_conflict = d_req & a_req;
    assign w_cnt_inc  = r_burst_cnt + 8'd1;

    always_comb begin
        w_d_gnt = 1'b0;
        w_a_gnt = 1'b0;
        case (w_pol)
            S_VIS: begin
                w_d_gnt = d_req;
                w_a_gnt = a_req & ~d_req;
            end
            S_BURST: begin
                w_a_gnt = a_req;
            end
            default: begin
                if (w_conflict) begin
                    w_d_gnt = (r_rr_last == ID_A);
                    w_a_gnt = (r_rr_last == ID_D);
                end else begin
                    w_d_gnt = d_req;
                    w_a_gnt = a_req;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_BLANK;
            r_rr_last   <= ID_A;
            r_burst_cnt <= '0;
            r_rom_addr  <= '0;
            r_d_rvalid  <= 1'b0;
            r_a_rvalid  <= 1'b0;
        end else begin
            if (w_d_gnt)      r_rom_addr <= d_addr;
            else if (w_a_gnt) r_rom_addr <= a_addr;

            r_d_rvalid <= w_tag_out.valid & (w_tag_out.id == ID_D);
            r_a_rvalid <= w_tag_out.valid & (w_tag_out.id == ID_A);

            if (vis_active) begin
                r_state     <= S_VIS;
                r_burst_cnt <= '0;
            end else begin
                case (w_pol)
                    S_BURST: begin
                        // Leaving a burst hands the next conflict to the display.
                        if (!a_burst || (w_a_gnt && (w_cnt_inc == BURST_MAX_C))) begin
                            r_state     <= S_BLANK;
                            r_burst_cnt <= '0;
                            r_rr_last   <= ID_A;
                        end else if (w_a_gnt) begin
                            r_burst_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state <= S_BLANK;
                        if (w_conflict) r_rr_last <= w_a_gnt ? ID_A : ID_D;
                        if (w_a_gnt && a_burst) begin
                            if (BURST_ALLOWED) begin
                                r_state     <= S_BURST;
                                r_burst_cnt <= 8'd1;
                            end else begin
                                r_rr_last <= ID_A;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign w_tag_in = {(w_d_gnt | w_a_gnt), (w_a_gnt ? ID_A : ID_D)};

    rom_arb_tag_pipe #(
        .ROM_LAT (ROM_LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    assign d_gnt    = w_d_gnt;
    assign a_gnt    = w_a_gnt;
    assign rom_addr = r_rom_addr;
    assign d_rvalid = r_d_rvalid;
    assign a_rvalid = r_a_rvalid;
    assign d_rdata  = rom_data;
    assign a_rdata  = rom_data;

`ifdef ROM_ARB_STATS_EN
    logic [15:0] r_stat_d;
    logic [15:0] r_stat_a;
    logic [15:0] r_stat_blk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_d   <= '0;
            r_stat_a   <= '0;
            r_stat_blk <= '0;
        end else begin
            if (w_d_gnt && (r_stat_d != 16'hFFFF))               r_stat_d   <= r_stat_d + 16'd1;
            if (w_a_gnt && (r_stat_a != 16'hFFFF))               r_stat_a   <= r_stat_a + 16'd1;
            if (d_req && !w_d_gnt && (r_stat_blk != 16'hFFFF))   r_stat_blk <= r_stat_blk + 16'd1;
        end
    end

    assign stat_d_grants  = r_stat_d;
    assign stat_a_grants  = r_stat_a;
    assign stat_d_blocked = r_stat_blk;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed and randomized bench for rom_arbiter against a behavioural
// arbitration model and a synchronous ROM model (ROM_LAT=1, BURST_MAX=4).
module tb_rom_arbiter;

    localparam int ADDR_W    = 17;
    localparam int DATA_W    = 12;
    localparam int ROM_LAT   = 1;
    localparam int BURST_MAX = 4;

    logic              clk;
    logic              rst_n;
    logic              vis_active;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic              a_burst;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
`ifdef ROM_ARB_STATS_EN
    logic [15:0]       stat_d_grants;
    logic [15:0]       stat_a_grants;
    logic [15:0]       stat_d_blocked;
`endif

    rom_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .ROM_LAT   (ROM_LAT),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vis_active (vis_active),
        .d_req      (d_req),
        .d_addr     (d_addr),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .a_req      (a_req),
        .a_addr     (a_addr),
        .a_burst    (a_burst),
        .a_gnt      (a_gnt),
        .a_rvalid   (a_rvalid),
        .a_rdata    (a_rdata),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data)
`ifdef ROM_ARB_STATS_EN
        ,
        .stat_d_grants  (stat_d_grants),
        .stat_a_grants  (stat_a_grants),
        .stat_d_blocked (stat_d_blocked)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return DATA_W'((a * 37) + (a >> 5) + 17'h0155);
    endfunction

    // Synchronous ROM: word for rom_addr appears ROM_LAT edges later.
    logic [DATA_W-1:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_word(rom_addr);
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[ROM_LAT-1];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: policy flags rather than a state encoding.
    typedef struct {
        int                due;
        bit                to_aux;
        logic [ADDR_W-1:0] addr;
    } ret_t;

    ret_t              exp_q[$];
    bit                m_in_burst;
    int                m_burst_len;
    bit                m_d_next;
    logic [ADDR_W-1:0] m_rom_addr;
    int                cyc = 0;

    task automatic model_reset();
        m_in_burst  = 1'b0;
        m_burst_len = 0;
        m_d_next    = 1'b1;
        m_rom_addr  = '0;
        exp_q.delete();
    endtask

    task automatic step();
        bit                dg, ag, both, rv_d, rv_a;
        logic [ADDR_W-1:0] raddr;
        ret_t              e;
        @(negedge clk);
        both = d_req && a_req;
        if (vis_active) begin
            dg = d_req;
            ag = a_req && !d_req;
        end else if (m_in_burst) begin
            dg = 1'b0;
            ag = a_req;
        end else if (both) begin
            dg = m_d_next;
            ag = !m_d_next;
        end else begin
            dg = d_req;
            ag = a_req;
        end
        chk("d_gnt", 32'(d_gnt), 32'(dg));
        chk("a_gnt", 32'(a_gnt), 32'(ag));

        rv_d  = 1'b0;
        rv_a  = 1'b0;
        raddr = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e     = exp_q.pop_front();
            rv_a  = e.to_aux;
            rv_d  = !e.to_aux;
            raddr = e.addr;
        end
        chk("d_rvalid", 32'(d_rvalid), 32'(rv_d));
        chk("a_rvalid", 32'(a_rvalid), 32'(rv_a));
        chk("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
        if (rv_d) chk("d_rdata", 32'(d_rdata), 32'(rom_word(raddr)));
        if (rv_a) chk("a_rdata", 32'(a_rdata), 32'(rom_word(raddr)));

        @(posedge clk);
        if (dg || ag) begin
            exp_q.push_back('{due: cyc + 1 + ROM_LAT, to_aux: ag, addr: (ag ? a_addr : d_addr)});
            m_rom_addr = ag ? a_addr : d_addr;
        end
        if (vis_active) begin
            m_in_burst  = 1'b0;
            m_burst_len = 0;
        end else if (m_in_burst) begin
            if (ag) m_burst_len++;
            if (!a_burst || m_burst_len == BURST_MAX) begin
                m_in_burst  = 1'b0;
                m_burst_len = 0;
                m_d_next    = 1'b1;
            end
        end else begin
            if (both) m_d_next = ag;
            if (ag && a_burst) begin
                if (BURST_MAX > 1) begin
                    m_in_burst  = 1'b1;
                    m_burst_len = 1;
                end else begin
                    m_d_next = 1'b1;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic drive(input bit vis, input bit dr, input bit ar, input bit ab);
        vis_active = vis;
        d_req      = dr;
        a_req      = ar;
        a_burst    = ab;
        d_addr     = ADDR_W'($urandom);
        a_addr     = ADDR_W'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("reset_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);
        rst_n = 1'b1;

        // Visible region: display always wins, addresses 0x100+k.
        for (int k = 0; k < 10; k++) begin
            drive(1, 1, 1, 1'($urandom));
            d_addr = ADDR_W'(17'h00100 + k);
            step();
        end
        drive(1, 0, 0, 0);
        repeat (3) step();
`ifdef ROM_ARB_STATS_EN
        chk("stat_d_grants", 32'(stat_d_grants), 32'd10);
        chk("stat_a_grants", 32'(stat_a_grants), 32'd0);
        chk("stat_d_blocked", 32'(stat_d_blocked), 32'd0);
`endif

        // Blanking round-robin.
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 1, 0);
            step();
        end

        // Burst cap with the display also asking.
        for (int k = 0; k < 12; k++) begin
            drive(0, 1, 1, 1);
            step();
        end

        // Burst abort by vis_active with burst_cnt at 2.
        drive(0, 0, 0, 0);
        repeat (2) step();
        drive(0, 0, 1, 1);
        repeat (2) step();
        drive(1, 1, 1, 1);
        step();
        drive(0, 0, 0, 0);
        repeat (3) step();

        // Requests withdrawn mid-burst: display stays held off.
        drive(0, 0, 1, 1);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 1);
            step();
        end
        drive(0, 0, 0, 0);
        repeat (3) step();

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0));
            step();
        end
        drive(0, 0, 0, 0);
        repeat (4) step();

        // Clean restart, then a grant followed by a reset pulse mid-flight.
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 1, 1, 0);
        step();
        drive(0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midrst_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("midrst_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
        step();
        drive(0, 1, 1, 0);
        step();
        drive(0, 0, 0, 0);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
